// File: rtl/buffered_roller_pkg.sv
// -----------------------------------------------------------------------------
// buffered_roller_pkg
// Shared definitions for the buffered_roller block and its FIFO.
//   elem_t      : default-width element type (8-bit).  Modules that take a
//                 DATA_WIDTH parameter declare their own per-instance element
//                 typedef of that width.
//   ptr_width() : ceil-log2 of an entry count, never less than 1, used to size
//                 pointers, occupancy counters and beat indices.
// Optional macro used by the files that import this package:
//   BUFFERED_ROLLER_ASSERT_EN - compiles in simulation assertions.
// -----------------------------------------------------------------------------
package buffered_roller_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] elem_t;

    // Bits needed to hold values 0..n-1 (minimum one bit).
    function automatic int ptr_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/unpacked_fifo.sv
// -----------------------------------------------------------------------------
// unpacked_fifo
// DEPTH-entry circular FIFO of IN_NUM-element vectors, first-word fall-through.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   wr_data/wr_valid/wr_ready : write side handshake
//   rd_data/rd_valid/rd_ready : read side handshake (rd_data is the head entry,
//                               driven combinationally from storage)
// wr_ready and rd_valid depend only on the registered occupancy count.
// Macro: BUFFERED_ROLLER_ASSERT_EN adds an occupancy-bound assertion.
// -----------------------------------------------------------------------------
module unpacked_fifo
    import buffered_roller_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IN_NUM     = 4,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data [IN_NUM],
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data [IN_NUM],
    output logic                  rd_valid,
    input  logic                  rd_ready
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = ptr_width(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef logic [DATA_WIDTH-1:0] data_t;

    data_t            mem_q [DEPTH][IN_NUM];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_fire;
    logic             rd_fire;

    assign wr_ready = (cnt_q != FULL_CNT);
    assign rd_valid = (cnt_q != '0);
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_valid && rd_ready;

    for (genvar gi = 0; gi < IN_NUM; gi++) begin : g_head
        assign rd_data[gi] = mem_q[rd_ptr_q][gi];
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_fire) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_fire) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({wr_fire, rd_fire})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage has no reset: stale entries are never visible because the
    // count gates rd_valid.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < IN_NUM; i++) begin
                mem_q[wr_ptr_q][i] <= wr_data[i];
            end
        end
    end

`ifdef BUFFERED_ROLLER_ASSERT_EN
    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        cnt_q <= FULL_CNT)
        else $error("unpacked_fifo: count exceeds DEPTH");
`endif

endmodule

// File: rtl/buffered_roller.sv
// -----------------------------------------------------------------------------
// buffered_roller
// Elastic vector buffer: a DEPTH-entry FIFO of IN_NUM-element vectors feeds a
// roller that emits each vector as IN_NUM/ROLL_NUM consecutive beats of
// ROLL_NUM elements, lowest-index elements first.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   data_in/data_in_valid/data_in_ready    : producer side, one vector
//   data_out/data_out_valid/data_out_ready : consumer side, one beat
// data_in_ready comes straight from the FIFO count (no path from
// data_out_ready).  Total capacity is DEPTH+1 vectors.
// Macro: BUFFERED_ROLLER_ASSERT_EN compiles in simulation assertions
// (divisibility, input stability under stall, count and beat-index bounds).
// -----------------------------------------------------------------------------
module buffered_roller
    import buffered_roller_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IN_NUM     = 4,
    parameter int ROLL_NUM   = 2,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in [IN_NUM],
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out [ROLL_NUM],
    output logic                  data_out_valid,
    input  logic                  data_out_ready
);

    localparam int BEATS = IN_NUM / ROLL_NUM;
    localparam int K_W   = ptr_width(BEATS);
    localparam logic [K_W-1:0] LAST_K = K_W'(BEATS - 1);

    typedef logic [DATA_WIDTH-1:0] data_t;

    data_t          fifo_head [IN_NUM];
    logic           fifo_valid;
    logic           fifo_ready;

    data_t          roll_q [IN_NUM];
    data_t          roll_d [IN_NUM];
    logic           full_q, full_d;
    logic [K_W-1:0] k_q, k_d;

    logic           beat_fire;
    logic           last_fire;

    unpacked_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .IN_NUM     (IN_NUM),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (data_in),
        .wr_valid (data_in_valid),
        .wr_ready (data_in_ready),
        .rd_data  (fifo_head),
        .rd_valid (fifo_valid),
        .rd_ready (fifo_ready)
    );

    assign data_out_valid = full_q;
    assign beat_fire      = full_q && data_out_ready;
    assign last_fire      = beat_fire && (k_q == LAST_K);
    // Loading while the last beat leaves keeps vectors back-to-back.
    assign fifo_ready     = !full_q || last_fire;

    always_comb begin
        roll_d = roll_q;
        full_d = full_q;
        k_d    = k_q;
        if (fifo_valid && fifo_ready) begin
            roll_d = fifo_head;
            full_d = 1'b1;
            k_d    = '0;
        end else if (last_fire) begin
            full_d = 1'b0;
            k_d    = '0;
        end else if (beat_fire) begin
            k_d = k_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IN_NUM; i++) begin
                roll_q[i] <= '0;
            end
            full_q <= 1'b0;
            k_q    <= '0;
        end else begin
            roll_q <= roll_d;
            full_q <= full_d;
            k_q    <= k_d;
        end
    end

    // Beat select: slice k of the roller register.
    always_comb begin
        for (int j = 0; j < ROLL_NUM; j++) begin
            data_out[j] = roll_q[j];
        end
        for (int b = 1; b < BEATS; b++) begin
            if (k_q == K_W'(b)) begin
                for (int j = 0; j < ROLL_NUM; j++) begin
                    data_out[j] = roll_q[b*ROLL_NUM + j];
                end
            end
        end
    end

`ifdef BUFFERED_ROLLER_ASSERT_EN
    if ((ROLL_NUM < 1) || (IN_NUM % ROLL_NUM != 0)) begin : g_bad_roll
        $error("buffered_roller: IN_NUM must be a multiple of ROLL_NUM");
    end

    logic [IN_NUM*DATA_WIDTH-1:0] data_in_flat;
    for (genvar gi = 0; gi < IN_NUM; gi++) begin : g_flat
        assign data_in_flat[gi*DATA_WIDTH +: DATA_WIDTH] = data_in[gi];
    end

    a_in_stable: assert property (@(posedge clk) disable iff (rst)
        (data_in_valid && !data_in_ready) |=> $stable(data_in_flat))
        else $error("buffered_roller: data_in changed while stalled");

    a_k_bound: assert property (@(posedge clk) disable iff (rst)
        int'(k_q) < BEATS)
        else $error("buffered_roller: beat index out of range");
`endif

endmodule

// File: tb/tb_buffered_roller.sv
module tb_buffered_roller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    // DEPTH = 4 instance
    logic [7:0] a_in [4];
    logic       a_iv, a_ir;
    logic [7:0] a_out [2];
    logic       a_ov, a_or;

    // DEPTH = 3 instance (pointer wrap)
    logic [7:0] b_in [4];
    logic       b_iv, b_ir;
    logic [7:0] b_out [2];
    logic       b_ov, b_or;

    buffered_roller #(.DATA_WIDTH(8), .IN_NUM(4), .ROLL_NUM(2), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (a_in),
        .data_in_valid  (a_iv),
        .data_in_ready  (a_ir),
        .data_out       (a_out),
        .data_out_valid (a_ov),
        .data_out_ready (a_or)
    );

    buffered_roller #(.DATA_WIDTH(8), .IN_NUM(4), .ROLL_NUM(2), .DEPTH(3)) dut3 (
        .clk            (clk),
        .rst            (rst),
        .data_in        (b_in),
        .data_in_valid  (b_iv),
        .data_in_ready  (b_ir),
        .data_out       (b_out),
        .data_out_valid (b_ov),
        .data_out_ready (b_or)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          iv;
        logic [31:0] vec;
        bit          ordy;
        bit          ev;
        bit          er;
        bit          cd;
        logic [15:0] eout;   // {elem1, elem0}
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [31:0] v);
        for (int e = 0; e < 4; e++) a_in[e] = v[e*8 +: 8];
    endtask

    task automatic drive_b(input logic [31:0] v);
        for (int e = 0; e < 4; e++) b_in[e] = v[e*8 +: 8];
    endtask

    function automatic logic [31:0] mkvec(input int n);
        logic [31:0] v;
        for (int e = 0; e < 4; e++) v[e*8 +: 8] = 8'(n*16 + e);
        return v;
    endfunction

    task automatic do_reset();
        rst  = 1'b1;
        a_iv = 1'b0;
        b_iv = 1'b0;
        a_or = 1'b0;
        b_or = 1'b0;
        drive_a(32'h0);
        drive_b(32'h0);
        step();
        step();
        rst = 1'b0;
    endtask

    logic [31:0] sv [8];
    logic [31:0] wv [50];

    initial begin
        int          n;
        int          beats;
        int          bubbles;
        bit          fire;
        bit          found;
        logic [31:0] v;

        // cycle-by-cycle table: check outputs, then apply inputs for next edge
        tbl[0]  = '{1'b1, 32'h44332211, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000};
        tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
        tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 16'h2211};
        tbl[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 16'h4433};
        tbl[4]  = '{1'b1, 32'hA4A3A2A1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
        tbl[5]  = '{1'b1, 32'hB4B3B2B1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
        tbl[6]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 16'hA2A1};
        tbl[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 16'hA4A3};
        tbl[8]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 16'hB2B1};
        tbl[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 16'hB2B1};
        tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 16'hB4B3};
        tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("tbl%0d_valid", i), 32'(a_ov), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_in_ready", i), 32'(a_ir), 32'(tbl[i].er));
            if (tbl[i].cd) chk($sformatf("tbl%0d_data", i), {16'h0, a_out[1], a_out[0]}, {16'h0, tbl[i].eout});
            $display("tbl %0d: valid=%0d out=%02h_%02h", i, a_ov, a_out[1], a_out[0]);
            a_iv = tbl[i].iv;
            drive_a(tbl[i].vec);
            a_or = tbl[i].ordy;
            step();
        end
        a_iv = 1'b0;

        // backpressure: capacity is DEPTH+1 vectors
        do_reset();
        n = 0;
        for (int c = 0; c < 12; c++) begin
            a_iv = 1'b1;
            drive_a(mkvec(n));
            fire = a_ir;
            step();
            if (fire) n++;
        end
        a_iv = 1'b0;
        chk("bp_accepted", 32'(n), 32'd5);
        chk("bp_in_ready", 32'(a_ir), 32'd0);
        a_or  = 1'b1;
        beats = 0;
        for (int c = 0; c < 20; c++) begin
            if (a_ov) begin
                v = mkvec(beats / 2);
                if (beats < 10) chk($sformatf("bp_beat%0d", beats), {16'h0, a_out[1], a_out[0]}, {16'h0, v[(beats%2)*16 +: 16]});
                $display("bp beat %0d: %02h_%02h", beats, a_out[1], a_out[0]);
                beats++;
            end
            step();
        end
        chk("bp_beat_count", 32'(beats), 32'd10);

        // streaming: no bubble between back-to-back vectors
        do_reset();
        for (int i = 0; i < 8; i++) sv[i] = $urandom;
        a_or = 1'b1;
        n = 0; beats = 0; bubbles = 0;
        for (int c = 0; c < 60 && beats < 16; c++) begin
            if (n < 8) begin
                a_iv = 1'b1;
                drive_a(sv[n]);
            end else begin
                a_iv = 1'b0;
            end
            fire = a_iv && a_ir;
            if (a_ov) begin
                v = sv[beats / 2];
                chk($sformatf("st_beat%0d", beats), {16'h0, a_out[1], a_out[0]}, {16'h0, v[(beats%2)*16 +: 16]});
                $display("stream beat %0d: %02h_%02h", beats, a_out[1], a_out[0]);
                beats++;
            end else if (beats > 0) begin
                bubbles++;
            end
            step();
            if (fire) n++;
        end
        a_iv = 1'b0;
        chk("st_beat_count", 32'(beats), 32'd16);
        chk("st_bubbles", 32'(bubbles), 32'd0);

        // pointer wrap on DEPTH=3 with random handshakes
        do_reset();
        for (int i = 0; i < 50; i++) wv[i] = $urandom;
        n = 0; beats = 0;
        for (int c = 0; c < 2000 && beats < 100; c++) begin
            if (!(b_iv && !b_ir)) begin
                if (n < 50) begin
                    b_iv = 1'($urandom_range(0, 1));
                    drive_b(wv[n]);
                end else begin
                    b_iv = 1'b0;
                end
            end
            b_or = 1'($urandom_range(0, 1));
            fire = b_iv && b_ir;
            if (b_ov && b_or) begin
                v = wv[beats / 2];
                chk($sformatf("wr_beat%0d", beats), {16'h0, b_out[1], b_out[0]}, {16'h0, v[(beats%2)*16 +: 16]});
                $display("wrap beat %0d: %02h_%02h", beats, b_out[1], b_out[0]);
                beats++;
            end
            step();
            if (fire) n++;
        end
        b_iv = 1'b0;
        chk("wr_beat_count", 32'(beats), 32'd100);

        // reset after the first beat of a vector
        do_reset();
        a_or = 1'b1;
        a_iv = 1'b1;
        drive_a(32'hD4D3D2D1);
        step();
        a_iv = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (a_ov) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("mr_wait_valid", 32'(found), 32'd1);
        chk("mr_first_beat", {16'h0, a_out[1], a_out[0]}, 32'h0000D2D1);
        step();             // first beat handshakes on this edge
        a_or = 1'b0;
        rst  = 1'b1;
        step();
        rst  = 1'b0;
        a_or = 1'b1;
        chk("mr_data_cleared", {16'h0, a_out[1], a_out[0]}, 32'h0);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("mr_valid%0d", c), 32'(a_ov), 32'd0);
            $display("after reset cycle %0d: valid=%0d", c, a_ov);
            step();
        end
        chk("mr_in_ready", 32'(a_ir), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
